dmem_io_bridge: RTL and testbench

//  Data-side memory system for the single-cycle MIPS core: sits downstream of the core's

---
 rtl/dmem_io_bridge.sv | 143 ++++++++++++++
 tb/tb_dmem_io_bridge.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_io_bridge.sv
// rtl/dmem_io_bridge.sv - data memory and memory-mapped I/O page (LED, timer/IRQ, TX FIFO)
module dmem_io_bridge #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] writedata_i,
    output logic [31:0] readdata_o,
    output logic [7:0]  leds_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        timer_irq_o
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Byte lane bits are ignored by every decode path
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr_i[1:0];

    logic [31:0]      ram_q [RAM_WORDS];
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [7:0]       led_q, led_d;
    logic [31:0]      timer_q, timer_d;
    logic [31:0]      cmp_q, cmp_d;
    logic             irq_q, irq_d;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             io_sel;
    logic [5:0]       reg_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic             wr_led, wr_timer, wr_cmp, wr_tx, wr_status;
    logic             fifo_full, fifo_empty, pop, push_ok, drop, irq_set;
    logic [7:0]       status;

    assign io_sel    = (addr_i[31:8] == IO_BASE[31:8]);
    assign reg_idx   = addr_i[7:2];
    assign ram_idx   = addr_i[RAM_AW+1:2];

    assign wr_led    = memwrite_i && io_sel && (reg_idx == 6'h00);
    assign wr_timer  = memwrite_i && io_sel && (reg_idx == 6'h01);
    assign wr_cmp    = memwrite_i && io_sel && (reg_idx == 6'h02);
    assign wr_tx     = memwrite_i && io_sel && (reg_idx == 6'h03);
    assign wr_status = memwrite_i && io_sel && (reg_idx == 6'h04);

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && tx_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok    = wr_tx && (!fifo_full || pop);
    assign drop       = wr_tx && fifo_full && !pop;
    assign irq_set    = (cmp_q != '0) && (timer_q == cmp_q);

    assign status      = {4'(count_q), ovf_q, irq_q, fifo_empty, fifo_full};
    assign leds_o      = led_q;
    assign tx_valid_o  = !fifo_empty;
    assign tx_data_o   = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign timer_irq_o = irq_q;

    // Data RAM: no reset, written only when the address misses the I/O page
    always_ff @(posedge clk_i) begin
        if (memwrite_i && !io_sel) begin
            ram_q[ram_idx] <= writedata_i;
        end
    end

    // Zero-latency load mux across RAM and I/O registers
    always_comb begin
        readdata_o = 32'h0;
        if (!io_sel) begin
            readdata_o = ram_q[ram_idx];
        end else begin
            case (reg_idx)
                6'h00:   readdata_o = {24'h0, led_q};
                6'h01:   readdata_o = timer_q;
                6'h02:   readdata_o = cmp_q;
                6'h04:   readdata_o = {24'h0, status};
                default: readdata_o = 32'h0;
            endcase
        end
    end

    // Next-state for I/O registers; sticky flags favour a set over a same-cycle clear
    always_comb begin
        led_d    = wr_led ? writedata_i[7:0] : led_q;
        cmp_d    = wr_cmp ? writedata_i : cmp_q;
        timer_d  = wr_timer ? 32'h0 : timer_q + 32'h1;
        irq_d    = irq_set || (irq_q && !(wr_status && writedata_i[2]));
        ovf_d    = drop || (ovf_q && !(wr_status && writedata_i[3]));
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // I/O state registers with asynchronous clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            led_q    <= '0;
            timer_q  <= '0;
            cmp_q    <= '0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            led_q    <= led_d;
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // TX FIFO storage; the tail slot equals the head slot when full, and the
    // head is read out before this edge overwrites it
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else if (push_ok) begin
            fifo_q[wr_ptr_q] <= writedata_i[7:0];
        end
    end
endmodule

// File: tb/tb_dmem_io_bridge.sv
// tb/tb_dmem_io_bridge.sv - directed self-checking bench for dmem_io_bridge
module tb_dmem_io_bridge;
    localparam logic [31:0] A_LED    = 32'hFFFF_FF00;
    localparam logic [31:0] A_TIMER  = 32'hFFFF_FF04;
    localparam logic [31:0] A_CMP    = 32'hFFFF_FF08;
    localparam logic [31:0] A_TX     = 32'hFFFF_FF0C;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    dmem_io_bridge #(.RAM_WORDS(64), .FIFO_DEPTH(4), .IO_BASE(32'hFFFF_FF00)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .memwrite_i  (memwrite),
        .addr_i      (addr),
        .writedata_i (writedata),
        .readdata_o  (readdata),
        .leds_o      (leds),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .timer_irq_o (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk_eq(tag, readdata, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] exp4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp5 [3] = '{8'hA3, 8'hA4, 8'h66};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // reset state
        tick(2);
        chk_eq("rst_leds", {24'h0, leds}, 32'h0);
        chk_eq("rst_valid", {31'h0, tx_valid}, 32'h0);
        chk_eq("rst_txdata", {24'h0, tx_data}, 32'h0);
        chk_eq("rst_irq", {31'h0, timer_irq}, 32'h0);
        chk_rd("rst_status", A_STATUS, 32'h02);
        chk_rd("rst_timer", A_TIMER, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // RAM write, overwrite through byte-offset address and aliasing
        store(32'h0000_0000, 32'h0BAD_0000);
        store(32'h0000_0010, 32'h1234_5678);
        store(32'h0000_0011, 32'hCAFE_F00D);
        chk_rd("ram_off11", 32'h0000_0010, 32'hCAFE_F00D);
        store(32'h0000_0110, 32'hDEAD_BEEF);
        store(32'h0000_0014, 32'h0000_0055);
        chk_rd("ram_alias", 32'h0000_0010, 32'hDEAD_BEEF);
        chk_rd("ram_lsbs", 32'h0000_0013, 32'hDEAD_BEEF);
        chk_rd("ram_next", 32'h0000_0114, 32'h0000_0055);

        // LED and unmapped offsets
        store(A_LED, 32'h0000_01A5);
        chk_eq("leds", {24'h0, leds}, 32'hA5);
        chk_rd("led_rd", A_LED, 32'hA5);
        chk_rd("unmapped", 32'hFFFF_FF40, 32'h0);
        chk_rd("txdata_rd", A_TX, 32'h0);
        chk_rd("ram0_kept", 32'h0000_0000, 32'h0BAD_0000);

        // Timer compare and sticky IRQ
        store(A_CMP, 32'd20);
        chk_rd("cmp_rd", A_CMP, 32'd20);
        store(A_TIMER, 32'h1234);
        chk_rd("timer_zero", A_TIMER, 32'd0);
        tick(20);
        chk_rd("timer_20", A_TIMER, 32'd20);
        chk_eq("irq_pre", {31'h0, timer_irq}, 32'h0);
        tick(1);
        chk_eq("irq_set", {31'h0, timer_irq}, 32'h1);
        chk_rd("status_irq", A_STATUS, 32'h06);
        store(A_STATUS, 32'h4);
        chk_eq("irq_clr", {31'h0, timer_irq}, 32'h0);
        store(A_TIMER, 32'h0);
        tick(20);
        chk_eq("irq_pre2", {31'h0, timer_irq}, 32'h0);
        store(A_STATUS, 32'h4);
        chk_eq("irq_setwins", {31'h0, timer_irq}, 32'h1);
        store(A_STATUS, 32'h4);
        chk_eq("irq_clr2", {31'h0, timer_irq}, 32'h0);

        // FIFO fill with overflow, then drain
        tx_ready = 1'b0;
        store(A_TX, 32'hFFFF_FF11);
        chk_eq("push1_valid", {31'h0, tx_valid}, 32'h1);
        chk_eq("push1_data", {24'h0, tx_data}, 32'h11);
        store(A_TX, 32'h22);
        store(A_TX, 32'h33);
        store(A_TX, 32'h44);
        store(A_TX, 32'h55);
        chk_rd("fill_status", A_STATUS, 32'h49);
        chk_eq("hold_data", {24'h0, tx_data}, 32'h11);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_eq("drain_valid", {31'h0, tx_valid}, 32'h1);
            chk_eq("drain_data", {24'h0, tx_data}, {24'h0, exp4[i]});
            tick(1);
        end
        chk_eq("drained_valid", {31'h0, tx_valid}, 32'h0);
        chk_eq("drained_data", {24'h0, tx_data}, 32'h0);
        chk_rd("drained_status", A_STATUS, 32'h0A);
        store(A_STATUS, 32'h8);
        chk_rd("ovf_clr", A_STATUS, 32'h02);

        // Full FIFO with simultaneous push and pop
        tx_ready = 1'b0;
        store(A_TX, 32'hA1);
        store(A_TX, 32'hA2);
        store(A_TX, 32'hA3);
        store(A_TX, 32'hA4);
        chk_rd("full_status", A_STATUS, 32'h41);
        tx_ready = 1'b1;
        store(A_TX, 32'h66);
        chk_rd("pushpop_status", A_STATUS, 32'h41);
        chk_eq("pushpop_head", {24'h0, tx_data}, 32'hA2);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_eq("pushpop_data", {24'h0, tx_data}, {24'h0, exp5[i]});
        end
        tick(1);
        chk_eq("pushpop_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Reset in the middle of activity
        store(A_TIMER, 32'h0);
        store(A_CMP, 32'd3);
        tick(3);
        chk_eq("irq_before_rst", {31'h0, timer_irq}, 32'h1);
        store(A_TX, 32'h01);
        store(A_TX, 32'h02);
        store(A_TX, 32'h03);
        chk_rd("pre_rst_status", A_STATUS, 32'h34);
        #2;
        reset = 1'b1;
        #1;
        chk_eq("arst_valid", {31'h0, tx_valid}, 32'h0);
        chk_eq("arst_irq", {31'h0, timer_irq}, 32'h0);
        chk_eq("arst_leds", {24'h0, leds}, 32'h0);
        chk_eq("arst_txdata", {24'h0, tx_data}, 32'h0);
        chk_rd("arst_status", A_STATUS, 32'h02);
        chk_rd("arst_cmp", A_CMP, 32'h0);
        tick(1);
        reset = 1'b0;
        chk_rd("ram_survives", 32'h0000_0010, 32'hDEAD_BEEF);
        chk_rd("ram0_survives", 32'h0000_0000, 32'h0BAD_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
